// File: rtl/datapath_pkg.sv
// Shared encodings, width constants and combinational helpers for the RISC datapath.
// Optional N/V status flags are enabled by defining DATAPATH_NV_FLAGS_EN.
package datapath_pkg;

  localparam int DW    = 16;
  localparam int NREGS = 8;
  localparam int AW    = 3;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_NOT = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_LSL1 = 2'b01,
    SH_LSR1 = 2'b10,
    SH_ASR1 = 2'b11
  } shift_e;

  function automatic logic [DW-1:0] shift_f(input logic [1:0] op, input logic [DW-1:0] b);
    logic [DW-1:0] r;
    case (shift_e'(op))
      SH_NONE: r = b;
      SH_LSL1: r = {b[DW-2:0], 1'b0};
      SH_LSR1: r = {1'b0, b[DW-1:1]};
      SH_ASR1: r = {b[DW-1], b[DW-1:1]};
      default: r = b;
    endcase
    return r;
  endfunction

  function automatic logic [DW-1:0] alu_f(input logic [1:0] op, input logic [DW-1:0] a,
                                          input logic [DW-1:0] b);
    logic [DW-1:0] r;
    case (alu_op_e'(op))
      ALU_ADD: r = a + b;
      ALU_SUB: r = a - b;
      ALU_AND: r = a & b;
      ALU_NOT: r = ~b;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Signed overflow only has meaning for add/sub; logic ops report none.
  function automatic logic ovf_f(input logic [1:0] op, input logic [DW-1:0] a,
                                 input logic [DW-1:0] b, input logic [DW-1:0] r);
    logic v;
    case (alu_op_e'(op))
      ALU_ADD: v = (a[DW-1] == b[DW-1]) && (r[DW-1] != a[DW-1]);
      ALU_SUB: v = (a[DW-1] != b[DW-1]) && (r[DW-1] != a[DW-1]);
      default: v = 1'b0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/risc_datapath_regfile.sv
// 8x16 register file: one synchronous write port, one combinational read port,
// asynchronous clear. No write-to-read bypass; a write is visible the next cycle.
module regfile
  import datapath_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          write,
  input  logic [AW-1:0] writenum,
  input  logic [DW-1:0] write_data,
  input  logic [AW-1:0] readnum,
  output logic [DW-1:0] read_data
);

  logic [DW-1:0] regs_q [NREGS];
  logic [DW-1:0] regs_d [NREGS];

  always_comb begin
    for (int i = 0; i < NREGS; i++) regs_d[i] = regs_q[i];
    if (write) regs_d[writenum] = write_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign read_data = regs_q[readnum];

endmodule

// File: rtl/risc_datapath.sv
// 16-bit execution datapath: register file, A/B operands, shifter, ALU, C and status.
// Define DATAPATH_NV_FLAGS_EN to add N_out/V_out alongside Z_out.
module risc_datapath
  import datapath_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] datapath_in,
  input  logic          vsel,
  input  logic [AW-1:0] writenum,
  input  logic          write,
  input  logic [AW-1:0] readnum,
  input  logic          loada,
  input  logic          loadb,
  input  logic [1:0]    shift,
  input  logic          asel,
  input  logic          bsel,
  input  logic [1:0]    ALUop,
  input  logic          loadc,
  input  logic          loads,
`ifdef DATAPATH_NV_FLAGS_EN
  output logic          N_out,
  output logic          V_out,
`endif
  output logic [DW-1:0] datapath_out,
  output logic          Z_out
);

  logic [DW-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic          z_q, z_d;
  logic [DW-1:0] read_data, write_data;
  logic [DW-1:0] ain, bin, alu_res;

  // Write-back from C uses the pre-edge C, so loadc in the same cycle does not race.
  assign write_data = vsel ? datapath_in : c_q;

  regfile u_regfile (
    .clk       (clk),
    .reset     (reset),
    .write     (write),
    .writenum  (writenum),
    .write_data(write_data),
    .readnum   (readnum),
    .read_data (read_data)
  );

  always_comb begin
    ain     = asel ? '0 : a_q;
    bin     = bsel ? {11'b0, datapath_in[4:0]} : shift_f(shift, b_q);
    alu_res = alu_f(ALUop, ain, bin);
    a_d     = loada ? read_data : a_q;
    b_d     = loadb ? read_data : b_q;
    c_d     = loadc ? alu_res : c_q;
    z_d     = loads ? (alu_res == '0) : z_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
      z_q <= 1'b0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
      c_q <= c_d;
      z_q <= z_d;
    end
  end

`ifdef DATAPATH_NV_FLAGS_EN
  logic n_q, n_d, v_q, v_d;

  always_comb begin
    n_d = loads ? alu_res[DW-1] : n_q;
    v_d = loads ? ovf_f(ALUop, ain, bin, alu_res) : v_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n_q <= 1'b0;
      v_q <= 1'b0;
    end else begin
      n_q <= n_d;
      v_q <= v_d;
    end
  end

  assign N_out = n_q;
  assign V_out = v_q;
`endif

  assign datapath_out = c_q;
  assign Z_out        = z_q;

endmodule

// File: tb/tb_risc_datapath.sv
// Self-checking bench for risc_datapath: directed test-plan sequences, async reset
// checks, then randomized cycles against an arithmetic reference model.
module tb_risc_datapath;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] datapath_in;
  logic        vsel, write, loada, loadb, asel, bsel, loadc, loads;
  logic [2:0]  writenum, readnum;
  logic [1:0]  shift, ALUop;
  logic [15:0] datapath_out;
  logic        Z_out;
`ifdef DATAPATH_NV_FLAGS_EN
  logic        N_out, V_out;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  risc_datapath dut (
    .clk         (clk),
    .reset       (reset),
    .datapath_in (datapath_in),
    .vsel        (vsel),
    .writenum    (writenum),
    .write       (write),
    .readnum     (readnum),
    .loada       (loada),
    .loadb       (loadb),
    .shift       (shift),
    .asel        (asel),
    .bsel        (bsel),
    .ALUop       (ALUop),
    .loadc       (loadc),
    .loads       (loads),
`ifdef DATAPATH_NV_FLAGS_EN
    .N_out       (N_out),
    .V_out       (V_out),
`endif
    .datapath_out(datapath_out),
    .Z_out       (Z_out)
  );

  // Reference state, held as plain integers.
  int m_r [8];
  int m_a, m_b, m_c;
  int m_z, m_n, m_v;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int to_signed(input int x);
    return (x >= 32768) ? x - 65536 : x;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_r[i] = 0;
    m_a = 0; m_b = 0; m_c = 0; m_z = 0; m_n = 0; m_v = 0;
  endtask

  // Next state computed from the pre-edge inputs and state.
  task automatic model_step();
    int rd, ain, bsh, bin, res, wd, s;
    if (reset) begin
      model_reset();
      return;
    end
    rd = m_r[readnum];
    ain = asel ? 0 : m_a;
    case (shift)
      2'd0: bsh = m_b;
      2'd1: bsh = (m_b * 2) % 65536;
      2'd2: bsh = m_b / 2;
      default: bsh = m_b / 2 + (m_b >= 32768 ? 32768 : 0);
    endcase
    bin = bsel ? (int'(datapath_in) % 32) : bsh;
    s = 0;
    case (ALUop)
      2'd0: begin res = (ain + bin) % 65536; s = to_signed(ain) + to_signed(bin); end
      2'd1: begin res = (ain - bin + 65536) % 65536; s = to_signed(ain) - to_signed(bin); end
      2'd2: res = ain & bin;
      default: res = 65535 - bin;
    endcase
    wd = vsel ? int'(datapath_in) : m_c;
    if (write) m_r[writenum] = wd;
    if (loada) m_a = rd;
    if (loadb) m_b = rd;
    if (loadc) m_c = res;
    if (loads) begin
      m_z = (res == 0) ? 1 : 0;
      m_n = (res >= 32768) ? 1 : 0;
      m_v = (ALUop[1] == 1'b0 && (s > 32767 || s < -32768)) ? 1 : 0;
    end
  endtask

  task automatic idle();
    datapath_in = '0; vsel = 0; writenum = '0; write = 0; readnum = '0;
    loada = 0; loadb = 0; shift = '0; asel = 0; bsel = 0; ALUop = '0;
    loadc = 0; loads = 0;
  endtask

  task automatic cycle(input string tag);
    #1;
    if (reset) begin
      check({tag, "_rst_c"}, datapath_out, 16'h0);
      check({tag, "_rst_z"}, {15'b0, Z_out}, 16'h0);
    end
    model_step();
    @(posedge clk);
    #1;
    check({tag, "_c"}, datapath_out, 16'(m_c));
    check({tag, "_z"}, {15'b0, Z_out}, 16'(m_z));
`ifdef DATAPATH_NV_FLAGS_EN
    check({tag, "_n"}, {15'b0, N_out}, 16'(m_n));
    check({tag, "_v"}, {15'b0, V_out}, 16'(m_v));
`endif
  endtask

  task automatic wr(input logic [2:0] n, input logic [15:0] val);
    idle(); vsel = 1; write = 1; writenum = n; datapath_in = val;
    cycle("wr");
  endtask

  task automatic ld(input logic [2:0] n, input logic la, input logic lb);
    idle(); readnum = n; loada = la; loadb = lb;
    cycle("ld");
  endtask

  task automatic op(input logic [1:0] sh, input logic [1:0] alu, input logic lc, input logic ls);
    idle(); shift = sh; ALUop = alu; loadc = lc; loads = ls;
    cycle("op");
  endtask

  task automatic txn(input string name, input logic [15:0] exp_c);
    check(name, datapath_out, exp_c);
    $display("txn %s: datapath_out=%0d Z=%0b", name, datapath_out, Z_out);
  endtask

  initial begin
    idle();
    reset = 1;
    model_reset();
    #2;
    check("reset_c", datapath_out, 16'h0);
    check("reset_z", {15'b0, Z_out}, 16'h0);
    @(negedge clk);
    reset = 0;

    // R1 + (R0 << 1) = 16, then write back to R2 and read R2 out through ~0 path.
    wr(0, 16'd7); wr(1, 16'd2);
    ld(1, 1, 0); ld(0, 0, 1);
    op(2'd1, 2'd0, 1, 0);
    txn("add_lsl", 16'd16);
    idle(); vsel = 0; write = 1; writenum = 3'd2; cycle("wb");
    ld(2, 0, 1);
    idle(); asel = 1; ALUop = 2'd0; loadc = 1; cycle("rd2");
    txn("r2_readback", 16'd16);

    wr(0, 16'd7); wr(1, 16'd2);
    ld(1, 0, 1); ld(0, 1, 0);
    op(2'd0, 2'd1, 1, 0);
    txn("sub", 16'd5);

    wr(0, 16'd12); wr(1, 16'd7);
    ld(1, 1, 0); ld(0, 0, 1);
    op(2'd2, 2'd2, 1, 0);
    txn("and_lsr", 16'd6);

    wr(0, 16'h8003);
    ld(0, 0, 1);
    op(2'd3, 2'd3, 1, 0);
    txn("not_asr", 16'h3FFE);

    // Write from C while loadc changes C: the register must capture the old C.
    idle(); vsel = 0; write = 1; writenum = 3'd5; ALUop = 2'd0; asel = 1; bsel = 1;
    datapath_in = 16'd9; loadc = 1; cycle("wb_race");
    txn("wb_race_newc", 16'd9);
    ld(5, 0, 1);
    idle(); asel = 1; loadc = 1; cycle("rd5");
    txn("wb_race_oldc", 16'h3FFE);

    wr(0, 16'd1);
    ld(0, 0, 1);
    op(2'd0, 2'd3, 0, 1);
    check("z_clear", {15'b0, Z_out}, 16'h0);
    ld(0, 1, 1);
    op(2'd0, 2'd1, 0, 1);
    check("z_set", {15'b0, Z_out}, 16'h1);

    // Async reset mid-cycle with loads/writes pending; reset must win.
    idle(); write = 1; vsel = 1; datapath_in = 16'hBEEF; loadc = 1; loads = 1; bsel = 1;
    #3;
    reset = 1;
    #1;
    check("async_c", datapath_out, 16'h0);
    check("async_z", {15'b0, Z_out}, 16'h0);
    model_reset();
    cycle("rst_hold");
    @(negedge clk);
    reset = 0;
    ld(0, 0, 1);
    op(2'd0, 2'd3, 1, 0);
    txn("r0_after_rst", 16'hFFFF);
    idle(); asel = 1; bsel = 1; datapath_in = 16'h001F; ALUop = 2'd0; loadc = 1;
    cycle("imm");
    txn("imm31", 16'd31);

    // Randomized phase, including occasional async reset pulses.
    for (int i = 0; i < 400; i++) begin
      datapath_in = 16'($urandom);
      vsel = 1'($urandom); write = 1'($urandom); writenum = 3'($urandom);
      readnum = 3'($urandom); loada = 1'($urandom); loadb = 1'($urandom);
      shift = 2'($urandom); asel = ($urandom_range(0, 3) == 0);
      bsel = ($urandom_range(0, 3) == 0); ALUop = 2'($urandom);
      loadc = 1'($urandom); loads = 1'($urandom);
      reset = ($urandom_range(0, 49) == 0);
      cycle("rand");
    end
    reset = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
